// File: rtl/tl_pkg.sv
// Shared encodings for the traffic-light pin-interface monitor: phases,
// lamp-pattern classes, default dwell limits, error codes and the 7-segment table.
package tl_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RED         = 3'd1,
    RED_YELLOW  = 3'd2,
    GREEN       = 3'd3,
    GREEN_BLINK = 3'd4,
    YELLOW      = 3'd5,
    RESYNC      = 3'd6
  } phase_t;

  typedef enum logic [2:0] {
    C_DARK,
    C_R,
    C_RY,
    C_G,
    C_Y,
    C_ILL
  } lamp_cls_t;

  localparam int unsigned T_RED_DEF         = 9;
  localparam int unsigned T_RED_YELLOW_DEF  = 3;
  localparam int unsigned T_GREEN_DEF       = 9;
  localparam int unsigned T_GREEN_BLINK_DEF = 5;
  localparam int unsigned T_YELLOW_DEF      = 3;

  localparam logic [2:0] E_PATTERN  = 3'd1;
  localparam logic [2:0] E_TRANS    = 3'd2;
  localparam logic [2:0] E_BLINK    = 3'd3;
  localparam logic [2:0] E_OVERSTAY = 3'd4;
  localparam logic [2:0] E_EARLY    = 3'd5;
  localparam logic [2:0] E_SEG_BAD  = 3'd6;
  localparam logic [2:0] E_DIGIT    = 3'd7;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  function automatic lamp_cls_t classify(input logic r, input logic y, input logic g);
    case ({r, y, g})
      3'b100:  classify = C_R;
      3'b110:  classify = C_RY;
      3'b001:  classify = C_G;
      3'b010:  classify = C_Y;
      3'b000:  classify = C_DARK;
      default: classify = C_ILL;
    endcase
  endfunction

  // Legal successor of each timed phase; the loop closes YELLOW back to RED.
  function automatic phase_t succ(input phase_t p);
    case (p)
      RED:         succ = RED_YELLOW;
      RED_YELLOW:  succ = GREEN;
      GREEN:       succ = GREEN_BLINK;
      GREEN_BLINK: succ = YELLOW;
      YELLOW:      succ = RED;
      default:     succ = IDLE;
    endcase
  endfunction

  // Lamp class that holds a phase (for GREEN_BLINK: the class that enters it).
  function automatic lamp_cls_t hold_cls(input phase_t p);
    case (p)
      RED:         hold_cls = C_R;
      RED_YELLOW:  hold_cls = C_RY;
      GREEN:       hold_cls = C_G;
      GREEN_BLINK: hold_cls = C_DARK;
      YELLOW:      hold_cls = C_Y;
      default:     hold_cls = C_ILL;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the controller's 7-segment encoder.
// Unknown patterns decode to valid=0, digit=4'hF.
module seg7_decode
  import tl_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b0;
    digit = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (pattern == seg_of(4'(i))) begin
        valid = 1'b1;
        digit = 4'(i);
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic-light controller pins: tracks phase,
// decodes the countdown digit, latches sticky errors. All outputs 1 cycle late.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int unsigned T_RED         = T_RED_DEF,
  parameter int unsigned T_RED_YELLOW  = T_RED_YELLOW_DEF,
  parameter int unsigned T_GREEN       = T_GREEN_DEF,
  parameter int unsigned T_GREEN_BLINK = T_GREEN_BLINK_DEF,
  parameter int unsigned T_YELLOW      = T_YELLOW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clr_err,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic [6:0] seg_in,
  output logic [2:0] phase,
  output logic [3:0] digit,
  output logic       err_seq,
  output logic       err_time,
  output logic       err_seg,
  output logic [2:0] err_code,
  output logic [7:0] cycles
);

  phase_t    st, st_nxt;
  lamp_cls_t cls;
  logic [3:0] cnt, cnt_nxt, limit, seg_val;
  logic       sync, sync_nxt, blink_dark, seg_ok, moved, timed, bad;
  logic [7:1] e;
  logic [2:0] first_code;

  seg7_decode u_dec (
    .pattern (seg_in),
    .valid   (seg_ok),
    .digit   (seg_val)
  );

  assign cls   = classify(red, yellow, green);
  assign phase = st;

  always_comb begin
    case (st)
      RED:         limit = 4'(T_RED);
      RED_YELLOW:  limit = 4'(T_RED_YELLOW);
      GREEN:       limit = 4'(T_GREEN);
      GREEN_BLINK: limit = 4'(T_GREEN_BLINK);
      YELLOW:      limit = 4'(T_YELLOW);
      default:     limit = 4'd0;
    endcase
  end

  always_comb begin
    st_nxt   = st;
    sync_nxt = sync;
    bad      = 1'b0;
    e        = '0;
    case (st)
      IDLE: begin
        if (cls == C_R) begin
          st_nxt   = RED;
          sync_nxt = 1'b1;
        end else if (cls != C_DARK && cls != C_Y) begin
          bad = 1'b1;
        end
      end
      RESYNC: begin
        if (cls == C_R) begin
          st_nxt   = RED;
          sync_nxt = 1'b1;
        end
      end
      GREEN_BLINK: begin
        // Blink must alternate; blink_dark remembers the previous sample.
        if (cls == C_DARK || cls == C_G) e[3] = ((cls == C_DARK) == blink_dark);
        else if (cls == C_Y)             st_nxt = YELLOW;
        else                             bad = 1'b1;
      end
      default: begin
        if (cls != hold_cls(st)) begin
          if (cls == hold_cls(succ(st))) begin
            st_nxt = succ(st);
            if (st == YELLOW) sync_nxt = 1'b0;
          end else begin
            bad = 1'b1;
          end
        end
      end
    endcase
    if (bad) begin
      st_nxt = RESYNC;
      e[1]   = (cls == C_ILL);
      e[2]   = (cls != C_ILL);
    end

    moved   = (st_nxt != st);
    timed   = st inside {RED, RED_YELLOW, GREEN, GREEN_BLINK, YELLOW};
    cnt_nxt = moved ? 4'd0 : ((cnt == 4'hF) ? cnt : cnt + 4'd1);
    e[4]    = timed && !moved && (cnt >= limit);
    e[5]    = timed && moved && (cnt < limit) && !(st == RED && sync);

    e[6] = !seg_ok;
    if (seg_ok) begin
      if (st_nxt == RED) begin
        if (!sync_nxt)  e[7] = (seg_val != 4'(T_RED) - cnt_nxt);
        else if (moved) e[7] = (seg_val > 4'(T_RED));
        else            e[7] = (seg_val != digit - 4'd1);
      end else begin
        e[7] = (seg_val != 4'd0);
      end
    end
    // The countdown must have reached zero on the final RED sample.
    if (st == RED && moved && digit != 4'd0) e[7] = 1'b1;

    first_code = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (e[i]) first_code = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      cnt        <= 4'd0;
      sync       <= 1'b1;
      blink_dark <= 1'b0;
      digit      <= 4'd0;
      cycles     <= 8'd0;
      err_seq    <= 1'b0;
      err_time   <= 1'b0;
      err_seg    <= 1'b0;
      err_code   <= 3'd0;
    end else begin
      if (ena) begin
        st    <= st_nxt;
        cnt   <= cnt_nxt;
        sync  <= sync_nxt;
        digit <= seg_val;
        if (st_nxt == GREEN_BLINK) blink_dark <= (cls == C_DARK);
        if (st == YELLOW && st_nxt == RED && cycles != 8'hFF) cycles <= cycles + 8'd1;
      end
      if (clr_err) begin
        err_seq  <= 1'b0;
        err_time <= 1'b0;
        err_seg  <= 1'b0;
        err_code <= 3'd0;
      end else if (ena) begin
        err_seq  <= err_seq  | (|e[3:1]);
        err_time <= err_time | (|e[5:4]);
        err_seg  <= err_seg  | (|e[7:6]);
        if (!(err_seq || err_time || err_seg) && (|e)) err_code <= first_code;
      end
    end
  end

endmodule
